// File: rtl/adv_i2c_init.sv
// rtl/adv_i2c_init.sv - ADV7511 I2C init sequencer; ADV_I2C_READBACK_EN adds read-back verification
module adv_i2c_init #(
    parameter int         CLK_FREQ_HZ    = 50000000,
    parameter int         I2C_FREQ_HZ    = 100000,
    parameter logic [6:0] DEV_ADDR       = 7'h39,
    parameter int         POWERUP_CYCLES = 10000000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       hpd,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index
);
    localparam int          Q_RAW      = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int          Q          = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam logic [31:0] Q_LAST     = 32'(Q - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(POWERUP_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [3:0]  LAST_INDEX = 4'd11;

    typedef enum logic [3:0] {
        IDLE, WAIT, START, BYTE, ACK, STOP, NEXT, DONE, ERR
`ifdef ADV_I2C_READBACK_EN
        , RSTART, RBYTE, MNACK
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] tick_cnt, wait_cnt;
    logic [1:0]  qcnt, byte_sel;
    logic [2:0]  bit_cnt;
    logic [3:0]  index;
    logic [7:0]  retry, rom_reg, rom_dat, cur_byte;
    logic        hpd_m, hpd_s, hpd_q, sda_m, sda_s;
    logic        txn_ok, abort_pending, restart_pending;
    logic        running, qtick, slot_end, sample, bit_scl, scl_d, sda_d;
    logic        hpd_rise, hpd_fall;
`ifdef ADV_I2C_READBACK_EN
    logic        rd_phase;
    logic [7:0]  rd_data, rd_mask;
`endif

    assign busy     = !(state inside {IDLE, DONE, ERR});
    assign running  = busy && (state != WAIT);
    assign qtick    = running && (tick_cnt == '0);
    assign slot_end = qtick && (qcnt == 2'd3);
    assign sample   = qtick && (qcnt == 2'd1);
    assign bit_scl  = (qcnt == 2'd0) || (qcnt == 2'd3);
    assign hpd_rise = hpd_s && !hpd_q;
    assign hpd_fall = !hpd_s && hpd_q;

    always_comb begin
        rom_reg = 8'h00;
        rom_dat = 8'h00;
        case (index)
            4'd0:  begin rom_reg = 8'h41; rom_dat = 8'h10; end
            4'd1:  begin rom_reg = 8'h98; rom_dat = 8'h03; end
            4'd2:  begin rom_reg = 8'h9A; rom_dat = 8'hE0; end
            4'd3:  begin rom_reg = 8'h9C; rom_dat = 8'h30; end
            4'd4:  begin rom_reg = 8'h9D; rom_dat = 8'h61; end
            4'd5:  begin rom_reg = 8'hA2; rom_dat = 8'hA4; end
            4'd6:  begin rom_reg = 8'hA3; rom_dat = 8'hA4; end
            4'd7:  begin rom_reg = 8'hE0; rom_dat = 8'hD0; end
            4'd8:  begin rom_reg = 8'h15; rom_dat = 8'h05; end
            4'd9:  begin rom_reg = 8'h16; rom_dat = 8'h30; end
            4'd10: begin rom_reg = 8'hAF; rom_dat = 8'h06; end
            4'd11: begin rom_reg = 8'hD6; rom_dat = 8'hC0; end
            default: ;
        endcase
        case (byte_sel)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = rom_reg;
            2'd2:    cur_byte = rom_dat;
            default: cur_byte = {DEV_ADDR, 1'b1};
        endcase
`ifdef ADV_I2C_READBACK_EN
        // Register 0x41 bit 6 reflects live power-down state
        rd_mask = (rom_reg == 8'h41) ? 8'hBF : 8'hFF;
`endif
    end

    always_comb begin
        state_nxt = state;
        scl_d     = 1'b0;
        sda_d     = 1'b0;
        case (state)
            IDLE: if (hpd_s) state_nxt = WAIT;
            WAIT: begin
                if (!hpd_s) state_nxt = IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = START;
            end
            START: begin
                scl_d = qcnt[1];
                sda_d = 1'b1;
                if (slot_end) state_nxt = BYTE;
            end
            BYTE: begin
                scl_d = bit_scl;
                sda_d = ~cur_byte[bit_cnt];
                if (slot_end && bit_cnt == 3'd0) state_nxt = ACK;
            end
            ACK: begin
                scl_d = bit_scl;
                if (slot_end) begin
                    if (!txn_ok || abort_pending || byte_sel == 2'd2) state_nxt = STOP;
`ifdef ADV_I2C_READBACK_EN
                    else if (byte_sel == 2'd1 && rd_phase) state_nxt = RSTART;
                    else if (byte_sel == 2'd3) state_nxt = RBYTE;
`endif
                    else state_nxt = BYTE;
                end
            end
            STOP: begin
                scl_d = (qcnt == 2'd0);
                sda_d = !qcnt[1];
                if (slot_end) state_nxt = NEXT;
            end
            NEXT: begin
                if (slot_end) begin
                    if (abort_pending || restart_pending) state_nxt = hpd_s ? WAIT : IDLE;
                    else if (!txn_ok) state_nxt = (retry == RETRY_MAX) ? ERR : START;
`ifdef ADV_I2C_READBACK_EN
                    else if (!rd_phase) state_nxt = START;
`endif
                    else if (index == LAST_INDEX) state_nxt = DONE;
                    else state_nxt = START;
                end
            end
            DONE, ERR: if (hpd_rise) state_nxt = WAIT;
`ifdef ADV_I2C_READBACK_EN
            RSTART: begin
                scl_d = bit_scl;
                sda_d = qcnt[1];
                if (slot_end) state_nxt = BYTE;
            end
            RBYTE: begin
                scl_d = bit_scl;
                if (slot_end && bit_cnt == 3'd0) state_nxt = MNACK;
            end
            MNACK: begin
                scl_d = bit_scl;
                if (slot_end) state_nxt = STOP;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE; scl_oe <= 1'b0; sda_oe <= 1'b0;
            done <= 1'b0; error <= 1'b0; err_index <= 4'd0;
            tick_cnt <= '0; wait_cnt <= '0; qcnt <= 2'd0; bit_cnt <= 3'd0; byte_sel <= 2'd0;
            index <= 4'd0; retry <= 8'd0; txn_ok <= 1'b0;
            abort_pending <= 1'b0; restart_pending <= 1'b0;
            hpd_m <= 1'b0; hpd_s <= 1'b0; hpd_q <= 1'b0; sda_m <= 1'b1; sda_s <= 1'b1;
`ifdef ADV_I2C_READBACK_EN
            rd_phase <= 1'b0; rd_data <= 8'd0;
`endif
        end else begin
            hpd_m <= hpd; hpd_s <= hpd_m; hpd_q <= hpd_s;
            sda_m <= sda_in; sda_s <= sda_m;
            state  <= state_nxt;
            scl_oe <= scl_d;
            sda_oe <= sda_d;
            tick_cnt <= (!running || qtick) ? Q_LAST : tick_cnt - 32'd1;
            if (qtick) qcnt <= qcnt + 2'd1;
            wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : '0;
            if (hpd_rise) error <= 1'b0;
            case (state)
                WAIT: begin
                    index <= 4'd0; retry <= 8'd0;
                    abort_pending <= 1'b0; restart_pending <= 1'b0;
`ifdef ADV_I2C_READBACK_EN
                    rd_phase <= 1'b0;
`endif
                end
                START: if (slot_end) begin txn_ok <= 1'b1; byte_sel <= 2'd0; bit_cnt <= 3'd7; end
                BYTE: if (slot_end) bit_cnt <= bit_cnt - 3'd1;
                ACK: begin
                    if (sample && sda_s) txn_ok <= 1'b0;
                    if (slot_end) byte_sel <= byte_sel + 2'd1;
                end
                NEXT: if (slot_end) begin
                    if (abort_pending || restart_pending) begin
                        abort_pending <= 1'b0; restart_pending <= 1'b0;
                        index <= 4'd0; retry <= 8'd0;
`ifdef ADV_I2C_READBACK_EN
                        rd_phase <= 1'b0;
`endif
                    end else if (!txn_ok) begin
`ifdef ADV_I2C_READBACK_EN
                        rd_phase <= 1'b0;
`endif
                        if (retry == RETRY_MAX) begin error <= 1'b1; err_index <= index; end
                        else retry <= retry + 8'd1;
`ifdef ADV_I2C_READBACK_EN
                    end else if (!rd_phase) begin
                        rd_phase <= 1'b1;
`endif
                    end else begin
`ifdef ADV_I2C_READBACK_EN
                        rd_phase <= 1'b0;
`endif
                        retry <= 8'd0;
                        index <= index + 4'd1;
                        if (index == LAST_INDEX) done <= 1'b1;
                    end
                end
`ifdef ADV_I2C_READBACK_EN
                RSTART: if (slot_end) byte_sel <= 2'd3;
                RBYTE: begin
                    if (sample) rd_data <= {rd_data[6:0], sda_s};
                    if (slot_end) bit_cnt <= bit_cnt - 3'd1;
                end
                MNACK: if (slot_end && ((rd_data ^ rom_dat) & rd_mask) != 8'd0) txn_ok <= 1'b0;
`endif
                default: ;
            endcase
            // Flagged after the NEXT handling so an edge on the same cycle is never lost
            if (hpd_rise && running) restart_pending <= 1'b1;
            if (hpd_fall && running) abort_pending <= 1'b1;
            if (hpd_fall || hpd_rise) done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adv_i2c_init.sv
// tb/tb_adv_i2c_init.sv - self-checking bench for adv_i2c_init with a behavioural I2C slave
module tb_adv_i2c_init;
    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       hpd = 1'b0;
    logic       scl_oe, sda_oe, sda_in, busy, done, error;
    logic [3:0] err_index;
    logic       slave_oe = 1'b0;
    logic       scl_line, sda_line;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | slave_oe);
    assign sda_in   = sda_line;

    adv_i2c_init #(
        .CLK_FREQ_HZ(8), .I2C_FREQ_HZ(1), .DEV_ADDR(7'h39),
        .POWERUP_CYCLES(20), .MAX_RETRY(3)
    ) dut (
        .clk_in(clk_in), .reset(reset), .hpd(hpd),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    always #5 clk_in = ~clk_in;

    // Slave model: decodes write transactions, NACKs the data byte of nack_reg up to nack_limit times
    logic [7:0] log_b0 [64];
    logic [7:0] log_b1 [64];
    logic [7:0] log_b2 [64];
    int         log_n [64];
    int         txn_cnt = 0, bitn = 0, byte_i = 0, nack_used = 0, seen_gen = 0;
    int         clear_gen = 0, nack_limit = 0;
    logic [7:0] nack_reg = 8'h00;
    logic       in_txn = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] cur = 8'h00;
    logic [7:0] bytes [3];

    always @(negedge clk_in) begin
        if (clear_gen != seen_gen) begin
            seen_gen = clear_gen;
            txn_cnt = 0; in_txn = 1'b0; bitn = 0; byte_i = 0; nack_used = 0; slave_oe = 1'b0;
        end
        if (scl_line && prev_scl && prev_sda && !sda_line) begin
            in_txn = 1'b1; bitn = 0; byte_i = 0;
        end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
            if (in_txn && txn_cnt < 64) begin
                log_b0[txn_cnt] = bytes[0]; log_b1[txn_cnt] = bytes[1];
                log_b2[txn_cnt] = bytes[2]; log_n[txn_cnt] = byte_i;
                txn_cnt++;
            end
            in_txn = 1'b0;
        end else if (in_txn && scl_line && !prev_scl) begin
            if (bitn < 8) begin
                cur = {cur[6:0], sda_line};
                bitn++;
                if (bitn == 8 && byte_i < 3) bytes[byte_i] = cur;
            end else begin
                bitn = 0;
                byte_i++;
            end
        end else if (in_txn && !scl_line && prev_scl) begin
            if (bitn == 8) begin
                if (byte_i == 2 && bytes[1] == nack_reg && (nack_limit < 0 || nack_used < nack_limit)) begin
                    slave_oe = 1'b0;
                    nack_used++;
                end else begin
                    slave_oe = 1'b1;
                end
            end else begin
                slave_oe = 1'b0;
            end
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic restart_dut(input logic h);
        reset = 1'b1;
        hpd = h;
        repeat (3) @(negedge clk_in);
        clear_gen++;
        reset = 1'b0;
    endtask

    task automatic wait_end(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_in);
            if (!busy && (done || error)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] nack_reg;
        int         nack_limit;
        int         exp_txns;
        logic       exp_done;
        logic       exp_error;
        logic [3:0] exp_idx;
        logic [7:0] exp_last_reg;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_reg [12];
    logic [7:0] exp_dat [12];

    initial begin
        logic ok;
        int   last, lat;

        exp_reg = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2, 8'hA3, 8'hE0, 8'h15, 8'h16, 8'hAF, 8'hD6};
        exp_dat = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4, 8'hA4, 8'hD0, 8'h05, 8'h30, 8'h06, 8'hC0};
        vecs[0] = '{8'h00,  0, 12, 1'b1, 1'b0, 4'd0, 8'hD6};
        vecs[1] = '{8'h16, -1, 13, 1'b0, 1'b1, 4'd9, 8'h16};
        vecs[2] = '{8'h9A,  1, 13, 1'b1, 1'b0, 4'd0, 8'hD6};
        vecs[3] = '{8'h41, -1,  4, 1'b0, 1'b1, 4'd0, 8'h41};
        vecs[4] = '{8'hD6,  2, 14, 1'b1, 1'b0, 4'd0, 8'hD6};

        // Reset state with hpd low
        restart_dut(1'b0);
        repeat (5) @(negedge clk_in);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);

        for (int v = 0; v < 5; v++) begin
            nack_reg = vecs[v].nack_reg;
            nack_limit = vecs[v].nack_limit;
            restart_dut(1'b1);
            wait_end(8000, ok);
            check($sformatf("v%0d_finished", v), 32'(ok), 32'd1);
            check($sformatf("v%0d_txns", v), 32'(txn_cnt), 32'(vecs[v].exp_txns));
            check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_error));
            check($sformatf("v%0d_err_index", v), 32'(err_index), 32'(vecs[v].exp_idx));
            check($sformatf("v%0d_bus_released", v), 32'({scl_oe, sda_oe, busy}), 32'd0);
            last = (txn_cnt > 0) ? txn_cnt - 1 : 0;
            check($sformatf("v%0d_last_reg", v), 32'(log_b1[last]), 32'(vecs[v].exp_last_reg));
            if (v == 0) begin
                for (int i = 0; i < 12; i++) begin
                    check($sformatf("t%0d_addr", i), 32'(log_b0[i]), 32'h72);
                    check($sformatf("t%0d_reg", i), 32'(log_b1[i]), 32'(exp_reg[i]));
                    check($sformatf("t%0d_data", i), 32'(log_b2[i]), 32'(exp_dat[i]));
                end
            end
            if (v == 2) begin
                check("retry_first_reg", 32'(log_b1[2]), 32'h9A);
                check("retry_second_reg", 32'(log_b1[3]), 32'h9A);
                check("retry_then_next", 32'(log_b1[4]), 32'h9C);
            end
        end

        // HPD falls during the data byte of entry 5
        nack_reg = 8'h00;
        nack_limit = 0;
        restart_dut(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_in);
            if (txn_cnt == 5 && in_txn && byte_i == 2 && bitn >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("hpd_fall_reached", 32'(ok), 32'd1);
        hpd = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_in);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("hpd_fall_idle", 32'(ok), 32'd1);
        check("hpd_fall_txns", 32'(txn_cnt), 32'd6);
        check("hpd_fall_bytes", 32'(log_n[5]), 32'd3);
        check("hpd_fall_last", 32'({log_b1[5], log_b2[5]}), 32'hA2A4);
        check("hpd_fall_done", 32'(done), 32'd0);
        check("hpd_fall_bus", 32'({scl_oe, sda_oe, sda_line}), 32'b001);
        clear_gen++;
        @(negedge clk_in);
        hpd = 1'b1;
        lat = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk_in);
            if (sda_oe) begin
                lat = i;
                break;
            end
        end
        check("powerup_wait", 32'(lat >= 22 && lat <= 26), 32'd1);
        wait_end(8000, ok);
        check("rerun_finished", 32'(ok), 32'd1);
        check("rerun_txns", 32'(txn_cnt), 32'd12);
        check("rerun_first", 32'(log_b1[0]), 32'h41);
        check("rerun_done", 32'(done), 32'd1);

        // Reset during the register byte
        restart_dut(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_in);
            if (in_txn && byte_i == 1 && bitn == 4) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_byte_reached", 32'(ok), 32'd1);
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        check("mid_rst_outputs", 32'({scl_oe, sda_oe, busy}), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        clear_gen++;
        @(negedge clk_in);
        reset = 1'b0;
        wait_end(8000, ok);
        check("post_rst_finished", 32'(ok), 32'd1);
        check("post_rst_txns", 32'(txn_cnt), 32'd12);
        check("post_rst_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
